sweep_sequencer: RTL
====================

# sweep_sequencer

Frequency-sweep controller that drives the `out_freq` input of the NCO/CORDIC generator. Accepts one sweep configuration per handshake: start, stop, step, dwell and mode. Steps the generator frequency upward from start to stop. After every frequency change it blanks its output-valid flag for a fixed settle time, which covers the generator's divider and CORDIC pipeline latency. Sits between the host/register block and the generator; downstream consumers qualify generator samples with `out_valid`.

## Interface
- `DAT_WIDTH`, 16, width of all frequency words (matches generator `out_freq`/`discr_freq`)
- `DWELL_WIDTH`, 24, width of dwell count
- `SETTLE`, 48, blanking cycles after each frequency change; must be ≥ 1

- `clk` in 1: single clock
- `rst` in 1: asynchronous, active-high reset
- `cfg_valid` in 1: configuration offered
- `cfg_ready` out 1: high only in IDLE; transfer when `cfg_valid & cfg_ready`
- `start_freq` in DAT_WIDTH: first frequency, unsigned
- `stop_freq` in DAT_WIDTH: last frequency, unsigned
- `step_freq` in DAT_WIDTH: increment, unsigned
- `dwell` in DWELL_WIDTH: valid cycles per point; 0 is treated as 1
- `repeat_en` in 1: 1 restarts at start after the last point; 0 gives a single sweep
- `abort` in 1: terminate sweep
- `out_freq` out DAT_WIDTH: frequency word to the generator, registered
- `out_valid` out 1: generator output has settled at `out_freq`
- `busy` out 1: state ≠ IDLE
- `done` out 1: one-cycle pulse at the end of a single sweep
- `wrap` out 1: one-cycle pulse when a repeat sweep returns to start
- `cfg_err` out 1: one-cycle pulse when a configuration is rejected

## Operation
- Reset values (all outputs): `out_freq`=0, `out_valid`=0, `busy`=0, `done`=0, `wrap`=0, `cfg_err`=0, `cfg_ready`=1 (state IDLE).
- Configuration inputs are sampled only on the handshake edge and latched. Later input changes have no effect until the next handshake.
- Rejection rule: `start_freq > stop_freq`, or `step_freq == 0` with `start_freq != stop_freq`.
  - A rejected configuration still completes the handshake.
  - `cfg_err` pulses; state stays IDLE; `out_freq` is unchanged.
- FSM states: IDLE, SETTLE, DWELL.
  - IDLE → SETTLE on an accepted configuration. `out_freq`←start; settle counter←SETTLE−1.
  - SETTLE: `out_valid`=0; counter decrements. At 0 → DWELL, with dwell counter←max(dwell,1)−1.
  - DWELL: `out_valid`=1; counter decrements. At 0, the last-point test is `out_freq + step > stop` in DAT_WIDTH+1-bit arithmetic (no wrap-around).
    - Not last: `out_freq`←`out_freq`+step → SETTLE.
    - Last with `repeat_en`=1: `out_freq`←start, `wrap` pulses → SETTLE.
    - Last with `repeat_en`=0: `done` pulses → IDLE. `out_freq` holds the last point.
- Last point rule: the final point is the largest start+k·step ≤ stop. Stop itself is emitted only if it lies on the step grid.
- `abort` in SETTLE or DWELL: next state IDLE, `out_valid`←0, `out_freq` held, no `done`/`wrap`. `abort` in IDLE is ignored, so a simultaneous `cfg_valid` is accepted.
- `abort` on the same edge as a dwell end: abort wins; no `done`/`wrap` pulse.
- `rst` mid-sweep: immediate return to the reset values; the latched configuration is discarded.

## Timing
- Handshake at edge k: `out_freq`=start and `busy`=1 from edge k.
- `out_valid` rises at edge k+SETTLE and stays high for exactly max(dwell,1) cycles.
- On the edge where `out_valid` falls, `out_freq` updates in the same edge (or `done` asserts).
- Period per point: SETTLE + max(dwell,1) cycles.
- `done` and `busy`↓ occur on the same edge. `cfg_ready` rises on that edge, so a new handshake is possible the next cycle.
- `cfg_err` asserts one cycle after the rejected handshake. `cfg_ready` stays high throughout.

## Structure
- Shared package `sweep_pkg`:
  - state enum {IDLE, SETTLE, DWELL}
  - default width constants
  - `SETTLE` default, derived from the generator's divider width + CORDIC stage count + 2
- One sub-module `sweep_counter`: loadable down-counter with zero flag, width max(DWELL_WIDTH, clog2(SETTLE)). A single instance serves both SETTLE and DWELL.

## Test plan
- SETTLE=4; start=100, stop=130, step=10, dwell=3, repeat_en=0:
  - `out_freq` sequence 100, 110, 120, 130
  - each point: 4 cycles `out_valid`=0 then 3 cycles `out_valid`=1
  - `done` once, 28 cycles after the handshake
- start=100, stop=125, step=10: last point 120, then `done`; `out_freq` holds 120.
- repeat_en=1, start=0, stop=0xFFFF, step=0x8000: sequence 0, 0x8000, `wrap`, 0, …; no overflow to 0x0000 via addition.
- start=50, stop=40 → `cfg_err` pulse, `busy` stays 0. step=0, start=stop=7, dwell=0 → one point, 1 valid cycle, `done`.
- Timing corners:
  - `abort` during DWELL: next cycle `busy`=0, `out_valid`=0, `out_freq` held, no `done`.
  - `abort` coincident with the dwell-end edge: no `done`.
  - `rst` asserted mid-SETTLE: all outputs return to reset values without waiting for a clock.

Source files
------------

// File: rtl/sweep_pkg.sv
// Shared types and default constants for the frequency-sweep sequencer.
// Contents:
//   state_e         sequencer FSM states
//   DAT_WIDTH_DEF   default frequency word width (matches generator out_freq)
//   DWELL_WIDTH_DEF default dwell count width
//   SETTLE_DEF      default blanking time, covers generator divider + CORDIC pipe
//   max_u           helper for sizing the shared counter
package sweep_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSettle,
      StDwell
   } state_e;

   localparam int unsigned DAT_WIDTH_DEF     = 16;
   localparam int unsigned DWELL_WIDTH_DEF   = 24;

   // Generator latency components: divider width plus CORDIC stages, plus
   // two cycles for the input and output registers.
   localparam int unsigned GEN_DIV_WIDTH     = 30;
   localparam int unsigned GEN_CORDIC_STAGES = 16;
   localparam int unsigned SETTLE_DEF        = GEN_DIV_WIDTH + GEN_CORDIC_STAGES + 2;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sweep_sequencer_if.sv
// Configuration handshake and generator-facing outputs of the sweep sequencer.
// master: host / register block side (offers config, observes status).
// slave:  sweep_sequencer side.
// Signals: cfg_valid/cfg_ready handshake, start/stop/step frequency words,
//   dwell count, repeat_en, abort; out_freq/out_valid to generator and
//   consumers; busy, done, wrap, cfg_err status.
interface sweep_sequencer_if #(
   parameter int unsigned DAT_WIDTH   = sweep_pkg::DAT_WIDTH_DEF,
   parameter int unsigned DWELL_WIDTH = sweep_pkg::DWELL_WIDTH_DEF
);
   logic                   cfg_valid;
   logic                   cfg_ready;
   logic [DAT_WIDTH-1:0]   start_freq;
   logic [DAT_WIDTH-1:0]   stop_freq;
   logic [DAT_WIDTH-1:0]   step_freq;
   logic [DWELL_WIDTH-1:0] dwell;
   logic                   repeat_en;
   logic                   abort;
   logic [DAT_WIDTH-1:0]   out_freq;
   logic                   out_valid;
   logic                   busy;
   logic                   done;
   logic                   wrap;
   logic                   cfg_err;

   modport master (
      output cfg_valid, start_freq, stop_freq, step_freq, dwell, repeat_en, abort,
      input  cfg_ready, out_freq, out_valid, busy, done, wrap, cfg_err
   );

   modport slave (
      input  cfg_valid, start_freq, stop_freq, step_freq, dwell, repeat_en, abort,
      output cfg_ready, out_freq, out_valid, busy, done, wrap, cfg_err
   );
endinterface

// File: rtl/sweep_counter.sv
// Loadable down-counter with zero flag, shared by the settle and dwell phases.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   load      load load_val this cycle (takes priority over counting)
//   load_val  value to load
//   zero      count is zero
// Saturates at zero when not reloaded.
module sweep_counter #(
   parameter int unsigned WIDTH = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             zero
);

   logic [WIDTH-1:0] count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else if (load) begin
         count_q <= load_val;
      end else if (count_q != '0) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/sweep_sequencer.sv
// Frequency-sweep controller feeding the NCO/CORDIC generator.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       sweep_sequencer_if.slave: config handshake in, out_freq/out_valid
//             and busy/done/wrap/cfg_err status out
// Each point: SETTLE blanked cycles, then max(dwell,1) valid cycles.
module sweep_sequencer
   import sweep_pkg::*;
#(
   parameter int unsigned DAT_WIDTH   = DAT_WIDTH_DEF,
   parameter int unsigned DWELL_WIDTH = DWELL_WIDTH_DEF,
   parameter int unsigned SETTLE      = SETTLE_DEF
) (
   input logic               clk,
   input logic               rst,
   sweep_sequencer_if.slave  bus
);

   localparam int unsigned CNT_WIDTH = max_u(DWELL_WIDTH, $clog2(SETTLE));
   localparam logic [CNT_WIDTH-1:0] SETTLE_LOAD = CNT_WIDTH'(SETTLE - 1);

   state_e                 state_q, state_d;
   logic [DAT_WIDTH-1:0]   freq_q, freq_d;
   logic [DAT_WIDTH-1:0]   start_q, stop_q, step_q;
   logic [DWELL_WIDTH-1:0] dwell_q;
   logic                   repeat_q;
   logic                   done_q, done_d;
   logic                   wrap_q, wrap_d;
   logic                   err_q, err_d;
   logic                   cfg_latch;
   logic                   cnt_load;
   logic [CNT_WIDTH-1:0]   cnt_val;
   logic                   cnt_zero;

   logic                   handshake;
   logic                   reject;
   logic [DWELL_WIDTH-1:0] dwell_m1;
   logic [DAT_WIDTH:0]     next_sum;
   logic                   is_last;

   assign handshake = bus.cfg_valid & (state_q == StIdle);
   assign reject    = (bus.start_freq > bus.stop_freq) |
                      ((bus.step_freq == '0) & (bus.start_freq != bus.stop_freq));
   assign dwell_m1  = (bus.dwell == '0) ? '0 : bus.dwell - 1'b1;

   // One extra bit so a step past the top of the range is seen as "last"
   // instead of wrapping back to a small frequency. A zero step (only legal
   // with start == stop) is a single-point sweep.
   assign next_sum  = {1'b0, freq_q} + {1'b0, step_q};
   assign is_last   = (next_sum > {1'b0, stop_q}) | (step_q == '0);

   always_comb begin
      state_d   = state_q;
      freq_d    = freq_q;
      done_d    = 1'b0;
      wrap_d    = 1'b0;
      err_d     = 1'b0;
      cfg_latch = 1'b0;
      cnt_load  = 1'b0;
      cnt_val   = SETTLE_LOAD;
      unique case (state_q)
         StIdle: begin
            if (handshake) begin
               if (reject) begin
                  err_d = 1'b1;
               end else begin
                  cfg_latch = 1'b1;
                  freq_d    = bus.start_freq;
                  state_d   = StSettle;
                  cnt_load  = 1'b1;
               end
            end
         end
         StSettle: begin
            if (bus.abort) begin
               state_d = StIdle;
            end else if (cnt_zero) begin
               state_d  = StDwell;
               cnt_load = 1'b1;
               cnt_val  = CNT_WIDTH'(dwell_q);
            end
         end
         StDwell: begin
            // Abort beats a coincident dwell end: no done/wrap.
            if (bus.abort) begin
               state_d = StIdle;
            end else if (cnt_zero) begin
               if (!is_last) begin
                  freq_d   = next_sum[DAT_WIDTH-1:0];
                  state_d  = StSettle;
                  cnt_load = 1'b1;
               end else if (repeat_q) begin
                  freq_d   = start_q;
                  wrap_d   = 1'b1;
                  state_d  = StSettle;
                  cnt_load = 1'b1;
               end else begin
                  done_d  = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         freq_q   <= '0;
         start_q  <= '0;
         stop_q   <= '0;
         step_q   <= '0;
         dwell_q  <= '0;
         repeat_q <= 1'b0;
         done_q   <= 1'b0;
         wrap_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         freq_q  <= freq_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
         err_q   <= err_d;
         if (cfg_latch) begin
            start_q  <= bus.start_freq;
            stop_q   <= bus.stop_freq;
            step_q   <= bus.step_freq;
            dwell_q  <= dwell_m1;
            repeat_q <= bus.repeat_en;
         end
      end
   end

   sweep_counter #(
      .WIDTH (CNT_WIDTH)
   ) u_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .zero     (cnt_zero)
   );

   assign bus.cfg_ready = (state_q == StIdle);
   assign bus.busy      = (state_q != StIdle);
   assign bus.out_valid = (state_q == StDwell);
   assign bus.out_freq  = freq_q;
   assign bus.done      = done_q;
   assign bus.wrap      = wrap_q;
   assign bus.cfg_err   = err_q;

endmodule
